// File: rtl/tt_sweep_capture.sv
// Sweeps all 2**N_IN input vectors into a combinational DUT and streams one truth table per output.
// Latency: start -> first tt_valid is 1 + V*(SETTLE+1) cycles; done one cycle after the last beat.
// Backpressure: tt_ready low holds the current beat stable; optional tt_const port under TT_CONST_FLAG_EN.
module tt_sweep_capture #(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 18,
    parameter int SETTLE = 2,
    localparam int V  = 2 ** N_IN,
    localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [N_IN-1:0]   stim_out,
    input  logic [N_OUT-1:0]  resp_in,
    output logic              tt_valid,
    input  logic              tt_ready,
    output logic [IW-1:0]     tt_idx,
`ifdef TT_CONST_FLAG_EN
    output logic [1:0]        tt_const,
`endif
    output logic [V-1:0]      tt_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_EMIT,
        S_FIN
    } state_t;

    state_t                    state_q, state_d;
    logic [N_IN-1:0]           m_q, m_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [N_OUT-1:0][V-1:0]   table_q, table_d;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        table_d = table_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = '0;
                    cnt_d   = 4'(SETTLE);
                    idx_d   = '0;
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    for (int k = 0; k < N_OUT; k++) begin
                        table_d[k][m_q] = resp_in[k];
                    end
                    // m stays at V-1 so stim_out keeps the last vector through EMIT/FIN
                    if (m_q == N_IN'(V - 1)) begin
                        idx_d   = '0;
                        state_d = S_EMIT;
                    end else begin
                        m_d   = m_q + 1'b1;
                        cnt_d = 4'(SETTLE);
                    end
                end
            end
            S_EMIT: begin
                if (tt_ready) begin
                    if (idx_q == IW'(N_OUT - 1)) begin
                        idx_d   = '0;
                        state_d = S_FIN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Every bit is rewritten by each sweep before it is read, so no reset is needed
    always_ff @(posedge clk) begin
        table_q <= table_d;
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_FIN);
    assign stim_out = m_q;
    assign tt_valid = (state_q == S_EMIT);
    assign tt_idx   = idx_q;
    assign tt_data  = tt_valid ? table_q[idx_q] : '0;

`ifdef TT_CONST_FLAG_EN
    assign tt_const = tt_valid ? {&tt_data, ~|tt_data} : 2'b00;
`endif

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Scoreboard bench for tt_sweep_capture: combinational model DUT (SETTLE=2) and registered model DUT (SETTLE=0).
module tb_tt_sweep_capture;

    localparam int NO = 18;

    typedef struct packed {
        logic [4:0] idx;
        logic [3:0] data;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, start0, inv, tt_ready, tt_ready0;
    logic        busy, done, tt_valid, busy0, done0, tt_valid0;
    logic [1:0]  stim, stim0;
    logic [17:0] resp, resp0_q;
    logic [4:0]  tt_idx, tt_idx0;
    logic [3:0]  tt_data, tt_data0;
`ifdef TT_CONST_FLAG_EN
    logic [1:0]  tt_const, tt_const0;
`endif

    int errs = 0, checks = 0, cyc = 0, done_cnt = 0, exp_done = 0, rdy_mode = 0;
    beat_t q[$];
    beat_t q0[$];

    // Hand-derived truth tables, bit m = response to vector m (x0 = m[0], x1 = m[1])
    logic [3:0] tt_exp [NO] = '{4'b1010, 4'b1100, 4'b1000, 4'b0000, 4'b1111, 4'b0110,
                                4'b1110, 4'b0101, 4'b0011, 4'b0111, 4'b0001, 4'b1001,
                                4'b0010, 4'b0100, 4'b1011, 4'b1101, 4'b1010, 4'b1100};

    function automatic logic [17:0] model(input logic [1:0] s);
        logic x0, x1;
        x0 = s[0];
        x1 = s[1];
        model = {x1, x0, ~x0 | x1, x0 | ~x1, ~x0 & x1, x0 & ~x1, ~(x0 ^ x1), ~(x0 | x1),
                 ~(x0 & x1), ~x1, ~x0, x0 | x1, x0 ^ x1, 1'b1, 1'b0, x0 & x1, x1, x0};
    endfunction

    assign resp = model(stim) ^ {18{inv}};
    always @(posedge clk) resp0_q <= model(stim0);
    always @(posedge clk) cyc <= cyc + 1;

    tt_sweep_capture #(.N_IN(2), .N_OUT(18), .SETTLE(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .stim_out(stim), .resp_in(resp), .tt_valid(tt_valid), .tt_ready(tt_ready),
        .tt_idx(tt_idx),
`ifdef TT_CONST_FLAG_EN
        .tt_const(tt_const),
`endif
        .tt_data(tt_data)
    );

    tt_sweep_capture #(.N_IN(2), .N_OUT(18), .SETTLE(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .stim_out(stim0), .resp_in(resp0_q), .tt_valid(tt_valid0), .tt_ready(tt_ready0),
        .tt_idx(tt_idx0),
`ifdef TT_CONST_FLAG_EN
        .tt_const(tt_const0),
`endif
        .tt_data(tt_data0)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_done"}, 32'(done), 0);
        chk({nm, "_stim"}, 32'(stim), 0);
        chk({nm, "_valid"}, 32'(tt_valid), 0);
        chk({nm, "_idx"}, 32'(tt_idx), 0);
        chk({nm, "_data"}, 32'(tt_data), 0);
`ifdef TT_CONST_FLAG_EN
        chk({nm, "_const"}, 32'(tt_const), 0);
`endif
    endtask

    task automatic push_beats(input logic inv_v, input int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.idx  = 5'(k);
            b.data = tt_exp[k] ^ {4{inv_v}};
            q.push_back(b);
        end
    endtask

    task automatic sweep(input logic inv_v, input int mode, input bit poke, input bit timed);
        int t0, n;
        inv      = inv_v;
        rdy_mode = mode;
        push_beats(inv_v, NO);
        start = 1'b1;
        t0    = cyc;
        tick();
        start = 1'b0;
        chk("start_busy", 32'(busy), 1);
        chk("start_stim", 32'(stim), 0);
        n = 0;
        while (n < 500 && !done) begin
            start = poke && (n == 3 || n == 20);
            tick();
            n++;
        end
        start = 1'b0;
        chk("done_seen", 32'(done), 1);
        if (timed) chk("done_latency", 32'(cyc - t0), 31);
        tick();
        chk("busy_fall", 32'(busy), 0);
        chk("done_pulse", 32'(done), 0);
        exp_done++;
        rdy_mode = 0;
    endtask

    initial begin
        tt_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                1:       tt_ready = 1'($urandom_range(0, 1));
                2:       tt_ready = 1'b0;
                default: tt_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops and compares on each accepted beat, checks stall stability, counts done
    initial begin
        logic  pstall;
        beat_t pb, e;
        pstall = 1'b0;
        forever begin
            @(negedge clk);
            if (pstall) chk("stall_hold", {22'd0, tt_valid, tt_idx, tt_data}, {22'd0, 1'b1, pb.idx, pb.data});
            pstall  = tt_valid & ~tt_ready & ~rst;
            pb.idx  = tt_idx;
            pb.data = tt_data;
            if (tt_valid && tt_ready && !rst) begin
                if (q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL beat_unexpected: idx %0d data %b with empty queue", tt_idx, tt_data);
                end else begin
                    e = q.pop_front();
                    chk("beat", {23'd0, tt_idx, tt_data}, {23'd0, e.idx, e.data});
`ifdef TT_CONST_FLAG_EN
                    chk("const", 32'(tt_const), 32'({&e.data, ~|e.data}));
`endif
                end
            end
            if (tt_valid0 && tt_ready0 && !rst) begin
                if (q0.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL beat0_unexpected: idx %0d data %b with empty queue", tt_idx0, tt_data0);
                end else begin
                    e = q0.pop_front();
                    chk("beat0", {23'd0, tt_idx0, tt_data0}, {23'd0, e.idx, e.data});
                end
            end
            if (done) done_cnt++;
        end
    end

    initial begin
        beat_t b;
        int    t0, n;
        rst = 1'b1; start = 1'b0; start0 = 1'b0; inv = 1'b0; tt_ready0 = 1'b1;
        repeat (3) tick();
        check_reset("reset");
        chk("reset_busy0", 32'(busy0), 0);
        rst = 1'b0;
        tick();

        // Registered model with SETTLE=0: bit m captures f(m-1), bit 0 captures f(0)
        for (int k = 0; k < NO; k++) begin
            b.idx  = 5'(k);
            b.data = {tt_exp[k][2], tt_exp[k][1], tt_exp[k][0], tt_exp[k][0]};
            q0.push_back(b);
        end
        start0 = 1'b1;
        t0     = cyc;
        tick();
        start0 = 1'b0;
        n = 0;
        while (n < 200 && !done0) begin
            tick();
            n++;
        end
        chk("done0_seen", 32'(done0), 1);
        chk("done0_latency", 32'(cyc - t0), 23);
        tick();

        sweep(1'b0, 0, 1'b0, 1'b1);
        chk("done_count_1", 32'(done_cnt), 32'(exp_done));
        sweep(1'b1, 1, 1'b1, 1'b0);
        chk("done_count_2", 32'(done_cnt), 32'(exp_done));
        sweep(1'b0, 0, 1'b0, 1'b1);
        chk("done_count_3", 32'(done_cnt), 32'(exp_done));

        // Abort during APPLY at vector 2
        inv   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (n < 100 && stim != 2'd2) begin
            tick();
            n++;
        end
        chk("abortA_reach", 32'(stim), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("abortA");
        repeat (5) tick();

        // Abort during EMIT at beat 5: only beats 0..4 are accepted
        push_beats(1'b1, 5);
        inv   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (n < 100 && !(tt_valid && tt_idx == 5'd5)) begin
            tick();
            n++;
        end
        chk("abortB_reach", 32'(tt_idx), 5);
        rdy_mode = 2;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        rdy_mode = 0;
        check_reset("abortB");
        repeat (3) tick();
        chk("abort_no_done", 32'(done_cnt), 32'(exp_done));

        sweep(1'b0, 0, 1'b0, 1'b1);
        repeat (3) tick();
        chk("done_count_final", 32'(done_cnt), 32'(exp_done));
        chk("queue_empty", 32'(q.size()), 0);
        chk("queue0_empty", 32'(q0.size()), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
